crc_engine: RTL and testbench

CRC_ENGINE -- requirements
Module: crc_engine

---
 rtl/crc_pkg.sv | 43 ++++
 rtl/crc_engine_if.sv | 32 +++
 rtl/crc_step_comb.sv | 31 +++
 rtl/crc_engine.sv | 122 ++++++++++++
 tb/tb_crc_engine.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM state type, preset polynomials and the bit-level
// helpers used by the engine and its step calculator. Helpers operate on a
// 32-bit container and take the active width as an argument so every supported
// CRC width can share one implementation.
package crc_pkg;

  localparam int unsigned MAX_W = 32;
  localparam int unsigned LEN_W = 16;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } crc_state_e;

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v,
                                               input int unsigned w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

  // One serial LFSR step on a w-bit register held in the low bits of acc.
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] acc,
                                                 input logic             din,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int unsigned      w);
    logic             fb;
    logic [MAX_W-1:0] nxt;
    logic [MAX_W-1:0] mask;
    fb   = acc[5'(w - 1)] ^ din;
    nxt  = (acc << 1) ^ (fb ? poly : '0);
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    return nxt & mask;
  endfunction

endpackage

// File: rtl/crc_engine_if.sv
// Beat-in / result-out bus of the CRC engine.
//   in_*      : beat stream (valid/ready, data, last, abort) plus chk_crc
//   out_*     : result (valid/ready, crc, match flag, beat count)
// slave is the engine side, master is the producer/consumer side.
interface crc_engine_if
  import crc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CRC_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_abort;
  logic [CRC_W-1:0]  chk_crc;
  logic              out_valid;
  logic              out_ready;
  logic [CRC_W-1:0]  out_crc;
  logic              out_match;
  logic [LEN_W-1:0]  out_len;

  modport slave (
    input  in_valid, in_data, in_last, in_abort, chk_crc, out_ready,
    output in_ready, out_valid, out_crc, out_match, out_len
  );

  modport master (
    output in_valid, in_data, in_last, in_abort, chk_crc, out_ready,
    input  in_ready, out_valid, out_crc, out_match, out_len
  );
endinterface

// File: rtl/crc_step_comb.sv
// Combinational next-accumulator: applies DATA_W serial LFSR steps to acc_in,
// feeding data MSB first (LSB first when REFLECT_IN).
//   acc_in  : accumulator before the beat
//   data_in : beat payload
//   acc_out : accumulator after the beat
module crc_step_comb
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W     = 16,
  parameter int unsigned      CRC_W      = 16,
  parameter logic [CRC_W-1:0] POLY       = CRC_W'(CRC16_CCITT_POLY),
  parameter bit               REFLECT_IN = 1'b0
) (
  input  logic [CRC_W-1:0]  acc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [CRC_W-1:0]  acc_out
);

  // Unrolled bit-serial update, one step per payload bit.
  always_comb begin
    logic [CRC_W-1:0] acc;
    logic             din;
    acc = acc_in;
    for (int i = 0; i < int'(DATA_W); i++) begin
      din = REFLECT_IN ? data_in[i] : data_in[int'(DATA_W) - 1 - i];
      acc = CRC_W'(lfsr_step(MAX_W'(acc), din, MAX_W'(POLY), CRC_W));
    end
    acc_out = acc;
  end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine: accumulates one beat per cycle, produces a registered
// result (crc, match against chk_crc, beat count) one cycle after the last beat.
//   clk_in, rst : clock, asynchronous active-high reset
//   bus         : crc_engine_if slave (beat input, result output)
// in_ready is combinational from out_valid/out_ready so a stalled result
// back-pressures the beat stream.
module crc_engine
  import crc_pkg::*;
#(
  parameter int unsigned      DATA_W      = 16,
  parameter int unsigned      CRC_W       = 16,
  parameter logic [CRC_W-1:0] POLY        = CRC_W'(CRC16_CCITT_POLY),
  parameter logic [CRC_W-1:0] INIT        = '0,
  parameter logic [CRC_W-1:0] XOR_OUT     = '0,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0
) (
  input  logic         clk_in,
  input  logic         rst,
  crc_engine_if.slave  bus
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [CRC_W-1:0] out_crc_q, out_crc_d;
  logic             out_match_q, out_match_d;
  logic [LEN_W-1:0] out_len_q, out_len_d;

  logic             in_ready;
  logic             accept;
  logic [CRC_W-1:0] acc_base;
  logic [CRC_W-1:0] acc_next;
  logic [LEN_W-1:0] cnt_base;
  logic [LEN_W-1:0] cnt_inc;
  logic [CRC_W-1:0] crc_final;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // First beat of a frame always starts from INIT.
  assign acc_base = (state_q == ST_IDLE) ? INIT : acc_q;
  assign cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
  assign cnt_inc  = (cnt_base == LEN_MAX) ? cnt_base : cnt_base + LEN_W'(1);

  crc_step_comb #(
    .DATA_W     (DATA_W),
    .CRC_W      (CRC_W),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .acc_in  (acc_base),
    .data_in (bus.in_data),
    .acc_out (acc_next)
  );

  assign crc_final = (REFLECT_OUT ? CRC_W'(bit_rev(MAX_W'(acc_next), CRC_W)) : acc_next)
                     ^ XOR_OUT;

  // Next-state and result logic; abort outranks any beat in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_crc_d   = out_crc_q;
    out_match_d = out_match_q;
    out_len_d   = out_len_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (bus.in_abort) begin
      state_d = ST_IDLE;
      acc_d   = INIT;
      cnt_d   = '0;
    end else if (accept) begin
      if (bus.in_last) begin
        state_d     = ST_IDLE;
        acc_d       = INIT;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_crc_d   = crc_final;
        out_match_d = (crc_final == bus.chk_crc);
        out_len_d   = cnt_inc;
      end else begin
        state_d = ST_ACCUM;
        acc_d   = acc_next;
        cnt_d   = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= INIT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_crc_q   <= '0;
      out_match_q <= 1'b0;
      out_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_crc_q   <= out_crc_d;
      out_match_q <= out_match_d;
      out_len_q   <= out_len_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_crc   = out_crc_q;
  assign bus.out_match = out_match_q;
  assign bus.out_len   = out_len_q;

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: three 8-bit engines (XMODEM, INIT=FFFF, reflected)
// share one beat stream, a 16-bit-beat engine has its own. Expected CRCs come
// from polynomial long division over the augmented message bit string.
module tb_crc_engine;

  typedef bit          bitq_t[$];
  typedef logic [7:0]  byteq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_last, in_abort, out_ready;
  logic [7:0]  in_data;
  logic [15:0] chk_crc;
  logic        w_valid, w_last;
  logic [15:0] w_data;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  crc_engine_if #(.DATA_W(8),  .CRC_W(16)) if_x ();
  crc_engine_if #(.DATA_W(8),  .CRC_W(16)) if_f ();
  crc_engine_if #(.DATA_W(8),  .CRC_W(16)) if_r ();
  crc_engine_if #(.DATA_W(16), .CRC_W(16)) if_w ();

  assign if_x.in_valid = in_valid;  assign if_x.in_data = in_data;
  assign if_x.in_last  = in_last;   assign if_x.in_abort = in_abort;
  assign if_x.chk_crc  = chk_crc;   assign if_x.out_ready = out_ready;
  assign if_f.in_valid = in_valid;  assign if_f.in_data = in_data;
  assign if_f.in_last  = in_last;   assign if_f.in_abort = in_abort;
  assign if_f.chk_crc  = chk_crc;   assign if_f.out_ready = out_ready;
  assign if_r.in_valid = in_valid;  assign if_r.in_data = in_data;
  assign if_r.in_last  = in_last;   assign if_r.in_abort = in_abort;
  assign if_r.chk_crc  = chk_crc;   assign if_r.out_ready = out_ready;
  assign if_w.in_valid = w_valid;   assign if_w.in_data = w_data;
  assign if_w.in_last  = w_last;    assign if_w.in_abort = 1'b0;
  assign if_w.chk_crc  = 16'h0000;  assign if_w.out_ready = out_ready;

  crc_engine #(.DATA_W(8), .CRC_W(16)) u_x (.clk_in(clk), .rst(rst), .bus(if_x.slave));
  crc_engine #(.DATA_W(8), .CRC_W(16), .INIT(16'hFFFF)) u_f (.clk_in(clk), .rst(rst), .bus(if_f.slave));
  crc_engine #(.DATA_W(8), .CRC_W(16), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1))
    u_r (.clk_in(clk), .rst(rst), .bus(if_r.slave));
  crc_engine #(.DATA_W(16), .CRC_W(16)) u_w (.clk_in(clk), .rst(rst), .bus(if_w.slave));

  // Result handshakes seen on the XMODEM engine.
  always @(posedge clk) if (if_x.out_valid && out_ready) hs_cnt <= hs_cnt + 1;

  // ---------------- reference model ----------------
  function automatic bitq_t to_bits(input byteq_t q, input bit refl);
    bitq_t b;
    foreach (q[i]) for (int k = 0; k < 8; k++) b.push_back(refl ? q[i][k] : q[i][7-k]);
    return b;
  endfunction

  // Remainder of (M(x)*x^16 + INIT*x^n) mod (x^16 + 0x1021).
  function automatic logic [15:0] crc_model(input bitq_t bits, input logic [15:0] init,
                                            input bit refout);
    bitq_t       m;
    logic [16:0] p;
    logic [15:0] r, rr;
    int          n;
    p = {1'b1, 16'h1021};
    m = bits;
    n = bits.size();
    for (int k = 0; k < 16; k++) m.push_back(1'b0);
    for (int k = 0; k < 16; k++) m[k] = m[k] ^ init[15-k];
    for (int i = 0; i < n; i++)
      if (m[i]) for (int k = 0; k <= 16; k++) m[i+k] = m[i+k] ^ p[16-k];
    for (int k = 0; k < 16; k++) r[15-k] = m[n+k];
    for (int k = 0; k < 16; k++) rr[k] = r[15-k];
    return refout ? rr : r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat8(input logic [7:0] d, input logic last, input logic ab);
    in_valid = 1'b1; in_data = d; in_last = last; in_abort = ab;
    for (int n = 0; n < 20 && !if_x.in_ready; n++) tick();
    if (!if_x.in_ready) chk("ready_timeout8", 32'(if_x.in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0;
  endtask

  task automatic frame8(input byteq_t q, input bit gaps);
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      beat8(q[i], 1'(i == q.size() - 1), 1'b0);
    end
  endtask

  task automatic check8(input string tag, input byteq_t q);
    logic [15:0] ex, ef, er;
    ex = crc_model(to_bits(q, 1'b0), 16'h0000, 1'b0);
    ef = crc_model(to_bits(q, 1'b0), 16'hFFFF, 1'b0);
    er = crc_model(to_bits(q, 1'b1), 16'h0000, 1'b1);
    chk({tag, "_x_valid"}, 32'(if_x.out_valid), 32'd1);
    chk({tag, "_x_crc"},   32'(if_x.out_crc),   32'(ex));
    chk({tag, "_x_len"},   32'(if_x.out_len),   32'(q.size()));
    chk({tag, "_x_match"}, 32'(if_x.out_match), 32'(ex == chk_crc));
    chk({tag, "_f_crc"},   32'(if_f.out_crc),   32'(ef));
    chk({tag, "_f_match"}, 32'(if_f.out_match), 32'(ef == chk_crc));
    chk({tag, "_r_crc"},   32'(if_r.out_crc),   32'(er));
    chk({tag, "_r_len"},   32'(if_r.out_len),   32'(q.size()));
  endtask

  task automatic frame16(input byteq_t q);
    for (int i = 0; i < q.size(); i += 2) begin
      w_valid = 1'b1; w_data = {q[i], q[i+1]}; w_last = 1'(i + 2 >= q.size());
      for (int n = 0; n < 20 && !if_w.in_ready; n++) tick();
      if (!if_w.in_ready) chk("ready_timeout16", 32'(if_w.in_ready), 32'd1);
      tick();
      w_valid = 1'b0; w_last = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    byteq_t      msg, q;
    logic [15:0] e;
    int          h0;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_abort = 1'b0; in_data = 8'h00;
    out_ready = 1'b1; chk_crc = 16'h0000; w_valid = 1'b0; w_last = 1'b0; w_data = 16'h0;
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));

    #1;
    chk("rst_out_valid", 32'(if_x.out_valid), 32'd0);
    chk("rst_out_crc",   32'(if_x.out_crc),   32'd0);
    chk("rst_out_match", 32'(if_x.out_match), 32'd0);
    chk("rst_out_len",   32'(if_x.out_len),   32'd0);
    chk("rst_in_ready",  32'(if_x.in_ready),  32'd1);
    tick(); tick();
    rst = 1'b0;

    // Lone abort in IDLE must be harmless; then the check string.
    in_abort = 1'b1; tick(); in_abort = 1'b0;
    chk_crc = 16'h31C3;
    frame8(msg, 1'b0);
    chk("xmodem_crc",   32'(if_x.out_crc),   32'h31C3);
    chk("xmodem_len",   32'(if_x.out_len),   32'd9);
    chk("xmodem_match", 32'(if_x.out_match), 32'd1);
    chk("ccitt_false",  32'(if_f.out_crc),   32'h29B1);
    chk("kermit",       32'(if_r.out_crc),   32'h2189);
    check8("chk", msg);
    tick();
    chk("out_valid_clears", 32'(if_x.out_valid), 32'd0);

    chk_crc = 16'h31C2;
    frame8(msg, 1'b1);
    chk("nomatch", 32'(if_x.out_match), 32'd0);
    tick();

    // 16-bit beat equals two 8-bit beats MSB first.
    q = {8'h31, 8'h32};
    e = crc_model(to_bits(q, 1'b0), 16'h0000, 1'b0);
    frame8(q, 1'b0);
    chk("two_byte_x", 32'(if_x.out_crc), 32'(e));
    tick();
    frame16(q);
    chk("wide_valid", 32'(if_w.out_valid), 32'd1);
    chk("wide_crc",   32'(if_w.out_crc),   32'(e));
    chk("wide_len",   32'(if_w.out_len),   32'd1);
    tick();

    // Stalled result holds and back-pressures; release with a new last beat.
    out_ready = 1'b0;
    frame8(msg, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_in_ready", 32'(if_x.in_ready),  32'd0);
      chk("stall_valid",    32'(if_x.out_valid), 32'd1);
      chk("stall_crc",      32'(if_x.out_crc),   32'h31C3);
      chk("stall_len",      32'(if_x.out_len),   32'd9);
    end
    in_valid = 1'b1; in_data = 8'h41; in_last = 1'b1; out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(if_x.in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    q = {8'h41};
    chk("reload_valid", 32'(if_x.out_valid), 32'd1);
    chk("reload_crc",   32'(if_x.out_crc),   32'(crc_model(to_bits(q, 1'b0), 16'h0000, 1'b0)));
    chk("reload_len",   32'(if_x.out_len),   32'd1);
    tick();
    chk("reload_drain", 32'(if_x.out_valid), 32'd0);

    // Abort on beat 4, then the full frame: exactly one result.
    h0 = hs_cnt;
    beat8(8'h31, 1'b0, 1'b0); beat8(8'h32, 1'b0, 1'b0); beat8(8'h33, 1'b0, 1'b0);
    beat8(8'h34, 1'b0, 1'b1);
    chk("abort_no_result", 32'(if_x.out_valid), 32'd0);
    frame8(msg, 1'b0);
    chk("abort_then_crc", 32'(if_x.out_crc), 32'h31C3);
    chk("abort_then_len", 32'(if_x.out_len), 32'd9);
    tick();
    chk("abort_one_result", 32'(hs_cnt - h0), 32'd1);

    // Reset mid-frame and with a pending result.
    beat8(8'h31, 1'b0, 1'b0); beat8(8'h32, 1'b0, 1'b0);
    out_ready = 1'b0;
    q = {8'h55};
    frame8(q, 1'b0);
    chk("pend_valid", 32'(if_x.out_valid), 32'd1);
    rst = 1'b1; #1;
    chk("midrst_valid", 32'(if_x.out_valid), 32'd0);
    chk("midrst_crc",   32'(if_x.out_crc),   32'd0);
    chk("midrst_len",   32'(if_x.out_len),   32'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    beat8(8'h31, 1'b0, 1'b0); beat8(8'h32, 1'b0, 1'b0); beat8(8'h33, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("frame_rst_valid", 32'(if_x.out_valid), 32'd0);
    chk_crc = 16'h31C3;
    frame8(msg, 1'b0);
    chk("after_rst_crc", 32'(if_x.out_crc), 32'h31C3);
    chk("after_rst_len", 32'(if_x.out_len), 32'd9);
    tick();

    // Random frames on all engines.
    for (int f = 0; f < 10; f++) begin
      q = {};
      repeat ($urandom_range(1, 12)) q.push_back(8'($urandom));
      e = crc_model(to_bits(q, 1'b0), 16'h0000, 1'b0);
      chk_crc = (f % 2 == 0) ? e : 16'($urandom);
      frame8(q, 1'b1);
      check8("rand8", q);
      repeat ($urandom_range(1, 3)) tick();
      if (q.size() % 2 == 1) q.push_back(8'($urandom));
      frame16(q);
      chk("rand16_valid", 32'(if_w.out_valid), 32'd1);
      chk("rand16_crc",   32'(if_w.out_crc),   32'(crc_model(to_bits(q, 1'b0), 16'h0000, 1'b0)));
      chk("rand16_len",   32'(if_w.out_len),   32'(q.size() / 2));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
